mem_bus_arbiter: RTL and testbench

Shares the single 128x16 main data memory between the instruction cache and the data cache. Each cache issues block-level misses and write-backs (7-bit block address, 16-bit block). The arbiter grants one requester at a time, forwards its strobes to memory, and returns the memory result to that requester. The requester stays stalled through its busywait until then. It sits in Processor between both cache modules and data_mem.

---
 rtl/mem_bus_arbiter_pkg.sv | 20 ++
 rtl/mem_bus_arbiter_if.sv | 43 ++++
 rtl/mem_bus_arbiter_grant_select.sv | 59 +++++
 rtl/mem_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the cache/memory bus arbiter: FSM state and owner
// encodings plus default bus widths.
package mem_bus_arbiter_pkg;

    localparam int ADDR_W_DEF   = 7;
    localparam int DATA_W_DEF   = 16;
    localparam int MAX_SKIP_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two caches, the arbiter and the data memory.
// The slave view is the arbiter; the master view is everything around it.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
);
    // I-cache side
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_readdata;
    logic              i_busywait;
    // D-cache side
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_writedata;
    logic [DATA_W-1:0] d_readdata;
    logic              d_busywait;
    // Memory side
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;
    logic              mem_busywait;
    // Status: which requester completed the most recent transaction
    logic              last_grant;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_writedata,
               mem_readdata, mem_busywait,
        output i_readdata, i_busywait, d_readdata, d_busywait,
               mem_read, mem_write, mem_addr, mem_writedata, last_grant
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_writedata,
               mem_readdata, mem_busywait,
        input  i_readdata, i_busywait, d_readdata, d_busywait,
               mem_read, mem_write, mem_addr, mem_writedata, last_grant
    );

endinterface

// File: rtl/mem_bus_arbiter_grant_select.sv
// Grant priority for the memory arbiter. The D-cache wins contested grants
// unless the I-cache has already been passed over MAX_SKIP times in a row.
module mem_grant_select
    import mem_bus_arbiter_pkg::*;
#(
    parameter int MAX_SKIP = MAX_SKIP_DEF
) (
    input  logic   CLK,
    input  logic   reset,
    input  logic   i_req,
    input  logic   d_req,
    input  logic   grant_en,
    output owner_e owner_win
);

    localparam int                SKIP_W   = $clog2(MAX_SKIP + 1);
    localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(MAX_SKIP);

    logic [SKIP_W-1:0] skip_cnt_r;
    logic [SKIP_W-1:0] skip_cnt_s;

    // Pick the winner and compute the next consecutive-skip count for I.
    always_comb begin
        owner_win  = OWN_D;
        skip_cnt_s = skip_cnt_r;
        if (i_req && d_req) begin
            if (skip_cnt_r == SKIP_MAX) begin
                owner_win = OWN_I;
            end else begin
                owner_win = OWN_D;
            end
        end else if (i_req) begin
            owner_win = OWN_I;
        end else begin
            owner_win = OWN_D;
        end
        if (grant_en) begin
            if (owner_win == OWN_I) begin
                skip_cnt_s = {SKIP_W{1'b0}};
            end else if (i_req && (skip_cnt_r != SKIP_MAX)) begin
                skip_cnt_s = skip_cnt_r + 1'b1;
            end else begin
                skip_cnt_s = skip_cnt_r;
            end
        end else begin
            skip_cnt_s = skip_cnt_r;
        end
    end

    // Skip counter register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            skip_cnt_r <= {SKIP_W{1'b0}};
        end else begin
            skip_cnt_r <= skip_cnt_s;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing the single main data memory between the I-cache and the
// D-cache. One transaction at a time: IDLE -> GRANT (strobes held until the
// memory has been busy and gone idle) -> RESP (one cycle, owner released).
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_SKIP = MAX_SKIP_DEF
) (
    input  logic               CLK,
    input  logic               reset,
    mem_bus_arbiter_if.slave   bus
);

    arb_state_e        state_r, state_s;
    owner_e            owner_r, owner_s;
    owner_e            last_grant_r, last_grant_s;
    owner_e            win_s;
    logic              seen_busy_r, seen_busy_s;
    logic              mem_read_r, mem_read_s;
    logic              mem_write_r, mem_write_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
    logic [DATA_W-1:0] i_rdata_r, i_rdata_s;
    logic [DATA_W-1:0] d_rdata_r, d_rdata_s;
    logic              i_req_s, d_req_s, grant_en_s;
    logic              resp_i_s, resp_d_s;

    assign i_req_s    = bus.i_read;
    assign d_req_s    = bus.d_read | bus.d_write;
    assign grant_en_s = (state_r == ST_IDLE) & (i_req_s | d_req_s);
    assign resp_i_s   = (state_r == ST_RESP) & (owner_r == OWN_I);
    assign resp_d_s   = (state_r == ST_RESP) & (owner_r == OWN_D);

    mem_grant_select #(.MAX_SKIP(MAX_SKIP)) u_sel (
        .CLK       (CLK),
        .reset     (reset),
        .i_req     (i_req_s),
        .d_req     (d_req_s),
        .grant_en  (grant_en_s),
        .owner_win (win_s)
    );

    // Next-state and next-register values for the transaction FSM.
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        last_grant_s = last_grant_r;
        seen_busy_s  = seen_busy_r;
        mem_read_s   = mem_read_r;
        mem_write_s  = mem_write_r;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        i_rdata_s    = i_rdata_r;
        d_rdata_s    = d_rdata_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_en_s) begin
                    state_s     = ST_GRANT;
                    owner_s     = win_s;
                    seen_busy_s = 1'b0;
                    if (win_s == OWN_D) begin
                        // A simultaneous read+write from D is a write-back.
                        mem_read_s  = bus.d_read & ~bus.d_write;
                        mem_write_s = bus.d_write;
                        mem_addr_s  = bus.d_addr;
                        mem_wdata_s = bus.d_writedata;
                    end else begin
                        mem_read_s  = 1'b1;
                        mem_write_s = 1'b0;
                        mem_addr_s  = bus.i_addr;
                        mem_wdata_s = {DATA_W{1'b0}};
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (bus.mem_busywait) begin
                    seen_busy_s = 1'b1;
                end else begin
                    seen_busy_s = seen_busy_r;
                end
                if (seen_busy_r && !bus.mem_busywait) begin
                    state_s     = ST_RESP;
                    mem_read_s  = 1'b0;
                    mem_write_s = 1'b0;
                    // An abandoned read (request dropped) keeps the old data.
                    if (mem_read_r && (owner_r == OWN_D) && bus.d_read) begin
                        d_rdata_s = bus.mem_readdata;
                    end else if (mem_read_r && (owner_r == OWN_I) && bus.i_read) begin
                        i_rdata_s = bus.mem_readdata;
                    end else begin
                        d_rdata_s = d_rdata_r;
                    end
                end else begin
                    state_s = ST_GRANT;
                end
            end
            ST_RESP: begin
                state_s      = ST_IDLE;
                seen_busy_s  = 1'b0;
                last_grant_s = owner_r;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM and datapath registers; reset aborts any transaction at once.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_D;
            last_grant_r <= OWN_D;
            seen_busy_r  <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            i_rdata_r    <= {DATA_W{1'b0}};
            d_rdata_r    <= {DATA_W{1'b0}};
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            last_grant_r <= last_grant_s;
            seen_busy_r  <= seen_busy_s;
            mem_read_r   <= mem_read_s;
            mem_write_r  <= mem_write_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            i_rdata_r    <= i_rdata_s;
            d_rdata_r    <= d_rdata_s;
        end
    end

    // Stalls are combinational so a cache stalls in the cycle it requests.
    assign bus.i_busywait    = ~reset & i_req_s & ~resp_i_s;
    assign bus.d_busywait    = ~reset & d_req_s & ~resp_d_s;
    assign bus.mem_read      = mem_read_r;
    assign bus.mem_write     = mem_write_r;
    assign bus.mem_addr      = mem_addr_r;
    assign bus.mem_writedata = mem_wdata_r;
    assign bus.i_readdata    = i_rdata_r;
    assign bus.d_readdata    = d_rdata_r;
    assign bus.last_grant    = last_grant_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a behavioural memory with a settable
// busy time, a queue of expected memory transactions checked as each grant
// appears on the bus, and inline checks of stalls, latency and read data.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic CLK = 1'b0;
    logic reset;
    always #5 CLK = ~CLK;

    mem_bus_arbiter_if #(.ADDR_W(7), .DATA_W(16)) bus ();

    mem_bus_arbiter #(.ADDR_W(7), .DATA_W(16), .MAX_SKIP(3)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [15:0] wdata;
    } exp_t;
    exp_t exp_q[$];

    task automatic push_exp(input logic wr, input logic [6:0] a, input logic [15:0] wd);
        exp_t e;
        e.wr = wr; e.addr = a; e.wdata = wd;
        exp_q.push_back(e);
    endtask

    // Behavioural memory: busy for mem_lat cycles after a strobe appears.
    logic [15:0] mem_arr [128];
    int          mem_lat = 5;
    bit          mem_active;
    int          mem_cnt;

    always @(posedge CLK or posedge reset) begin
        if (reset) begin
            mem_active = 1'b0;
            mem_cnt = 0;
            bus.mem_busywait <= 1'b0;
            bus.mem_readdata <= 16'h0000;
        end else if (!mem_active) begin
            if (bus.mem_read || bus.mem_write) begin
                mem_active = 1'b1;
                mem_cnt = mem_lat - 1;
                bus.mem_busywait <= 1'b1;
                if (bus.mem_write) mem_arr[bus.mem_addr] = bus.mem_writedata;
            end
        end else if (bus.mem_busywait) begin
            if (mem_cnt > 0) begin
                mem_cnt--;
            end else begin
                bus.mem_busywait <= 1'b0;
                if (bus.mem_read) bus.mem_readdata <= mem_arr[bus.mem_addr];
            end
        end else if (!(bus.mem_read || bus.mem_write)) begin
            mem_active = 1'b0;
        end
    end

    // Grant monitor: each new memory strobe must match the next expected transaction.
    bit strobe_prev = 1'b0;
    always @(negedge CLK) begin
        exp_t e;
        if (!reset && (bus.mem_read || bus.mem_write) && !strobe_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_grant", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("grant_addr", bus.mem_addr, e.addr);
                check("grant_write", bus.mem_write, e.wr);
                check("grant_read", bus.mem_read, !e.wr);
                if (e.wr) check("grant_wdata", bus.mem_writedata, e.wdata);
            end
        end
        strobe_prev = bus.mem_read | bus.mem_write;
    end

    task automatic wait_resp(input bit is_d, input string tag, output int cycles);
        cycles = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            cycles++;
            if ((is_d ? bus.d_busywait : bus.i_busywait) == 1'b0) break;
        end
        check({tag, "_resp_seen"}, is_d ? bus.d_busywait : bus.i_busywait, 1'b0);
    endtask

    initial begin
        int c;
        reset = 1'b1;
        bus.i_read = 1'b0; bus.i_addr = 7'h00;
        bus.d_read = 1'b0; bus.d_write = 1'b0;
        bus.d_addr = 7'h00; bus.d_writedata = 16'h0000;
        for (int a = 0; a < 128; a++) mem_arr[a] = 16'h0000;
        mem_arr[7'h11] = 16'hBEEF;

        // Reset: stalls suppressed even with requests high
        bus.i_read = 1'b1; bus.d_read = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_i_busy", bus.i_busywait, 1'b0);
        check("rst_d_busy", bus.d_busywait, 1'b0);
        check("rst_mem_read", bus.mem_read, 1'b0);
        check("rst_mem_write", bus.mem_write, 1'b0);
        check("rst_i_rdata", bus.i_readdata, 16'h0000);
        check("rst_d_rdata", bus.d_readdata, 16'h0000);
        check("rst_last_grant", bus.last_grant, OWN_D);
        bus.i_read = 1'b0; bus.d_read = 1'b0;
        @(negedge CLK); reset = 1'b0;
        @(negedge CLK);

        // Single I read, memory busy 5 cycles
        mem_lat = 5;
        push_exp(1'b0, 7'h11, 16'h0000);
        bus.i_addr = 7'h11; bus.i_read = 1'b1;
        #1;
        check("i_busy_rise", bus.i_busywait, 1'b1);
        check("i_d_busy_idle", bus.d_busywait, 1'b0);
        @(negedge CLK);
        check("i_strobe", bus.mem_read, 1'b1);
        check("i_strobe_addr", bus.mem_addr, 7'h11);
        wait_resp(1'b0, "i_rd", c);
        check("i_rd_latency", c + 1, 8);
        check("i_rd_data", bus.i_readdata, 16'hBEEF);
        check("i_rd_d_busy", bus.d_busywait, 1'b0);
        @(negedge CLK);
        check("i_busy_one_cycle", bus.i_busywait, 1'b1);
        check("last_grant_i", bus.last_grant, OWN_I);
        bus.i_read = 1'b0;
        @(negedge CLK);

        // D write-back
        push_exp(1'b1, 7'h23, 16'h0704);
        bus.d_addr = 7'h23; bus.d_writedata = 16'h0704; bus.d_write = 1'b1;
        wait_resp(1'b1, "d_wr", c);
        check("d_wr_latency", c, 8);
        check("d_wr_rdata_hold", bus.d_readdata, 16'h0000);
        check("d_wr_mem", mem_arr[7'h23], 16'h0704);
        bus.d_write = 1'b0;
        @(negedge CLK);

        // Contention: D first, I right after with one IDLE cycle
        mem_arr[7'h50] = 16'h1234; mem_arr[7'h51] = 16'h5678;
        push_exp(1'b0, 7'h50, 16'h0000);
        push_exp(1'b0, 7'h51, 16'h0000);
        bus.d_addr = 7'h50; bus.d_read = 1'b1;
        bus.i_addr = 7'h51; bus.i_read = 1'b1;
        wait_resp(1'b1, "ct_d", c);
        check("ct_i_held", bus.i_busywait, 1'b1);
        check("ct_d_data", bus.d_readdata, 16'h1234);
        check("ct_i_data_hold", bus.i_readdata, 16'hBEEF);
        bus.d_read = 1'b0;
        wait_resp(1'b0, "ct_i", c);
        check("ct_i_latency", c, 9);
        check("ct_i_data", bus.i_readdata, 16'h5678);
        bus.i_read = 1'b0;
        @(negedge CLK);

        // Starvation: three D grants then I forced through
        mem_lat = 2;
        mem_arr[7'h30] = 16'hAAAA; mem_arr[7'h40] = 16'hBBBB;
        for (int k = 0; k < 3; k++) push_exp(1'b0, 7'h30, 16'h0000);
        push_exp(1'b0, 7'h40, 16'h0000);
        bus.d_addr = 7'h30; bus.d_read = 1'b1;
        bus.i_addr = 7'h40; bus.i_read = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_resp(1'b1, "sv_d", c);
            check("sv_i_held", bus.i_busywait, 1'b1);
            check("sv_d_data", bus.d_readdata, 16'hAAAA);
        end
        wait_resp(1'b0, "sv_i", c);
        check("sv_i_data", bus.i_readdata, 16'hBBBB);
        check("sv_d_held", bus.d_busywait, 1'b1);
        bus.i_read = 1'b0; bus.d_read = 1'b0;
        @(negedge CLK);
        // Skip count cleared: next contest goes to D again
        mem_arr[7'h31] = 16'hCCCC; mem_arr[7'h41] = 16'hDDDD;
        push_exp(1'b0, 7'h31, 16'h0000);
        push_exp(1'b0, 7'h41, 16'h0000);
        bus.d_addr = 7'h31; bus.d_read = 1'b1;
        bus.i_addr = 7'h41; bus.i_read = 1'b1;
        wait_resp(1'b1, "sv2_d", c);
        check("sv2_i_held", bus.i_busywait, 1'b1);
        check("sv2_d_data", bus.d_readdata, 16'hCCCC);
        bus.d_read = 1'b0;
        wait_resp(1'b0, "sv2_i", c);
        check("sv2_i_data", bus.i_readdata, 16'hDDDD);
        bus.i_read = 1'b0;
        @(negedge CLK);

        // d_read and d_write together: treated as a write
        mem_lat = 3;
        push_exp(1'b1, 7'h60, 16'h9999);
        bus.d_addr = 7'h60; bus.d_writedata = 16'h9999;
        bus.d_read = 1'b1; bus.d_write = 1'b1;
        wait_resp(1'b1, "rw", c);
        check("rw_mem", mem_arr[7'h60], 16'h9999);
        check("rw_rdata_hold", bus.d_readdata, 16'hCCCC);
        bus.d_read = 1'b0; bus.d_write = 1'b0;
        @(negedge CLK);

        // Abandoned D read: result discarded
        push_exp(1'b0, 7'h11, 16'h0000);
        bus.d_addr = 7'h11; bus.d_read = 1'b1;
        repeat (3) @(negedge CLK);
        bus.d_read = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge CLK);
            if (!bus.mem_read) break;
        end
        check("abn_complete", bus.mem_read, 1'b0);
        check("abn_d_busy", bus.d_busywait, 1'b0);
        check("abn_rdata_hold", bus.d_readdata, 16'hCCCC);
        @(negedge CLK);
        check("abn_rdata_hold2", bus.d_readdata, 16'hCCCC);

        // Reset in the middle of an I grant
        mem_lat = 5;
        push_exp(1'b0, 7'h11, 16'h0000);
        bus.i_addr = 7'h11; bus.i_read = 1'b1;
        @(negedge CLK);
        check("mr_strobe", bus.mem_read, 1'b1);
        @(negedge CLK);
        reset = 1'b1;
        #1;
        check("mr_strobe_drop", bus.mem_read, 1'b0);
        check("mr_i_busy", bus.i_busywait, 1'b0);
        check("mr_d_busy", bus.d_busywait, 1'b0);
        check("mr_i_rdata", bus.i_readdata, 16'h0000);
        @(negedge CLK);
        push_exp(1'b0, 7'h11, 16'h0000);
        reset = 1'b0;
        wait_resp(1'b0, "mr_rec", c);
        check("mr_rec_latency", c, 8);
        check("mr_rec_data", bus.i_readdata, 16'hBEEF);
        bus.i_read = 1'b0;
        repeat (2) @(negedge CLK);

        check("exp_queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
